uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001: The module SHALL have parameter CLKS_PER_BIT, default 434, giving clk_50M cycles per UART bit (50 MHz / 115200 baud).
REQ-002: The module SHALL have parameter HALF_BIT, default CLKS_PER_BIT/2 (217), giving clk_50M cycles from start-bit falling edge to start-bit mid-point.
REQ-003: The module SHALL have port clk_50M, input, 1 bit: the single 50 MHz clock; all logic rising-edge.
REQ-004: The module SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005: The module SHALL have port uart_rxd, input, 1 bit: serial line, idle high, asynchronous to clk_50M.
REQ-006: The module SHALL have port rx_read, input, 1 bit: consumer acknowledge, 1-cycle pulse, clears rx_full and rx_overrun.
REQ-007: The module SHALL have port rx_data, output, 8 bits: last correctly framed byte received.
REQ-008: The module SHALL have port rx_valid, output, 1 bit: 1-cycle pulse when rx_data is updated.
REQ-009: The module SHALL have port rx_full, output, 1 bit: unread byte held in rx_data.
REQ-010: The module SHALL have port rx_overrun, output, 1 bit: sticky flag, a byte arrived while rx_full=1.
REQ-011: The module SHALL have port rx_frame_err, output, 1 bit: 1-cycle pulse when the stop bit is sampled low.
REQ-012: The module SHALL have port rx_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013: uart_rxd SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized signal rxs.
REQ-014: The FSM SHALL have states IDLE, START, DATA, STOP and BREAK, plus one bit counter (ceil(log2(CLKS_PER_BIT)) bits) and a 3-bit bit index.
REQ-015: In IDLE, rxs=0 SHALL move the FSM to START with the counter cleared.
REQ-016: In START, at counter=HALF_BIT-1, rxs=0 SHALL move to DATA (counter and index cleared), and rxs=1 SHALL return to IDLE (glitch rejection, no output activity).
REQ-017: In DATA, at counter=CLKS_PER_BIT-1, rxs SHALL be shifted into the shift register LSB-first and the counter cleared; after index 7 the FSM SHALL move to STOP.
REQ-018: In STOP, at counter=CLKS_PER_BIT-1 with rxs=1, the FSM SHALL load rx_data from the shift register, pulse rx_valid on the next cycle, set rx_full and go to IDLE (mid-stop-bit, for resync margin).
REQ-019: In STOP, at counter=CLKS_PER_BIT-1 with rxs=0, the FSM SHALL pulse rx_frame_err, leave rx_data, rx_full and rx_overrun unchanged, and go to BREAK.
REQ-020: In BREAK, the FSM SHALL stay until rxs=1, then go to IDLE; a held-low line SHALL NOT start new frames.
REQ-021: A good byte completing while rx_full=1 and rx_read=0 SHALL overwrite rx_data, pulse rx_valid and set rx_overrun.
REQ-022: rx_read=1 in the same cycle as a good-byte load SHALL leave rx_full=1, leave rx_overrun unchanged, and load the new byte.
REQ-023: rx_read with rx_full=0 SHALL have no effect.
REQ-024: Latency from the uart_rxd falling edge of the start bit to rx_valid SHALL be 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles (±1 for the synchronizer).
REQ-025: rx_data SHALL remain stable between rx_valid pulses.

Reset
REQ-026: On reset_n=0, the module SHALL immediately force FSM=IDLE, counter=0, index=0, shift register=0x00, rx_data=0x00, rx_valid=0, rx_full=0, rx_overrun=0, rx_frame_err=0, rx_busy=0 and synchronizer=1, including mid-frame; a partial frame SHALL be discarded.
REQ-027: After reset_n rises, the module SHALL require a fresh falling edge on rxs before starting a frame.

Verification
REQ-028: Send 0x21 at an 8680 ns bit period (idle high, 1 stop bit) -> one rx_valid pulse, rx_data=0x21, rx_full=1, rx_frame_err=0, rx_valid within ±2 cycles of REQ-024.
REQ-029: Drive a 100 ns low glitch on idle uart_rxd -> rx_busy returns low after HALF_BIT+3 cycles; rx_valid, rx_frame_err and rx_data stay unchanged.
REQ-030: Send 0x55 with the stop bit driven low, hold low for 20 bit periods, then release and send 0x43 -> one rx_frame_err pulse, no frame during the low hold, then rx_data=0x43.
REQ-031: Send 0x43 then 0x65 back-to-back without rx_read -> rx_data=0x65 and rx_overrun=1; a subsequent rx_read pulse gives rx_full=0 and rx_overrun=0.
REQ-032: Assert reset_n=0 mid-data-bit 4 of a frame, release, then send 0x65 -> all outputs at reset values during reset, no output from the aborted frame, and rx_data=0x65 afterwards.
REQ-033: Loop back from the team's UART transmitter driving 0x21, 0x43 and 0x65 with rx_read after each -> three rx_valid pulses with matching data and no errors.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM, and a
// one-byte holding register with full/overrun tracking.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk_50M,
  input  logic       reset_n,
  input  logic       uart_rxd,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            full_q, full_d;
  logic            ovr_q, ovr_d;
  logic            ferr_q, ferr_d;
  logic            busy_q, busy_d;
  logic            meta_q, rxs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    full_d  = full_q;
    ovr_d   = ovr_q;
    ferr_d  = 1'b0;
    if (rx_read && full_q) begin
      full_d = 1'b0;
      ovr_d  = 1'b0;
    end
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          sh_d  = {rxs_q, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            // A read landing on the load cycle consumes the old byte, so the
            // new one is still unread and no overrun is recorded.
            data_d  = sh_q;
            valid_d = 1'b1;
            full_d  = 1'b1;
            ovr_d   = (full_q && !rx_read) ? 1'b1 : ovr_q;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxs_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      meta_q  <= uart_rxd;
      rxs_q   <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_full      = full_q;
  assign rx_overrun   = ovr_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames built from bytes, expected holding-register
// state tracked by a small byte/flag model.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = 8;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  logic       clk_50M = 1'b0, reset_n = 1'b0, uart_rxd = 1'b1, rx_read = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_full, rx_overrun, rx_frame_err, rx_busy;

  uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .clk_50M(clk_50M), .reset_n(reset_n), .uart_rxd(uart_rxd), .rx_read(rx_read),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy));

  always #10 clk_50M = ~clk_50M;

  int cyc = 0, valid_cnt = 0, ferr_cnt = 0, last_valid_cyc = 0;
  logic [7:0] last_valid_data = '0;
  always @(posedge clk_50M) cyc <= cyc + 1;
  always @(negedge clk_50M) begin
    if (rx_valid) begin
      valid_cnt       <= valid_cnt + 1;
      last_valid_cyc  <= cyc;
      last_valid_data <= rx_data;
    end
    if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  // Expected holding-register state
  logic [7:0] m_data = '0;
  bit         m_full = 0, m_ovr = 0;
  int         nvec = 0, nerr = 0, start_cyc = 0;

  function automatic void model_good(input logic [7:0] b);
    if (m_full) m_ovr = 1;
    m_full = 1;
    m_data = b;
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit stop);
    @(negedge clk_50M);
    start_cyc = cyc;
    uart_rxd  = 1'b0;
    repeat (CPB) @(negedge clk_50M);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk_50M);
    end
    uart_rxd = stop;
    repeat (CPB) @(negedge clk_50M);
  endtask

  task automatic pulse_read();
    @(negedge clk_50M) rx_read = 1'b1;
    @(negedge clk_50M) rx_read = 1'b0;
    if (m_full) begin m_full = 0; m_ovr = 0; end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_50M);
    nvec++;
    if ({rx_data, rx_valid, rx_full, rx_overrun, rx_frame_err, rx_busy} !== 13'h0) begin
      nerr++; $display("FAIL reset_hold: outs=%h want 0", {rx_data, rx_valid, rx_full, rx_overrun, rx_frame_err, rx_busy});
    end
    reset_n = 1'b1;
    repeat (2 * CPB) @(negedge clk_50M);
    nvec++;
    if ({rx_data, rx_full, rx_busy} !== 10'h0 || valid_cnt !== 0) begin
      nerr++; $display("FAIL reset_idle: data=%h full=%b busy=%b valids=%0d want 0", rx_data, rx_full, rx_busy, valid_cnt);
    end
  endtask

  task automatic test_single();
    int v0 = valid_cnt, f0 = ferr_cnt, lat;
    send_frame(8'h21, 1'b1);
    model_good(8'h21);
    lat = last_valid_cyc - start_cyc;
    nvec++;
    if (valid_cnt !== v0 + 1 || rx_data !== m_data || last_valid_data !== m_data) begin
      nerr++; $display("FAIL single_data: valids=%0d data=%h want %0d %h", valid_cnt - v0, rx_data, 1, m_data);
    end
    nvec++;
    if (rx_full !== 1'b1 || ferr_cnt !== f0) begin
      nerr++; $display("FAIL single_flags: full=%b ferrs=%0d want 1 0", rx_full, ferr_cnt - f0);
    end
    nvec++;
    if (lat < LAT - 2 || lat > LAT + 2) begin
      nerr++; $display("FAIL single_latency: got %0d want %0d+-2", lat, LAT);
    end
    pulse_read();
    nvec++;
    if (rx_full !== 1'b0) begin
      nerr++; $display("FAIL single_read: full=%b want 0", rx_full);
    end
  endtask

  task automatic test_glitch();
    int v0 = valid_cnt, f0 = ferr_cnt;
    logic [7:0] d0 = rx_data;
    @(negedge clk_50M) uart_rxd = 1'b0;
    repeat (5) @(negedge clk_50M);
    uart_rxd = 1'b1;
    nvec++;
    if (rx_busy !== 1'b1) begin
      nerr++; $display("FAIL glitch_busy_hi: busy=%b want 1", rx_busy);
    end
    repeat (HALF + 3) @(negedge clk_50M);
    nvec++;
    if (rx_busy !== 1'b0 || valid_cnt !== v0 || ferr_cnt !== f0 || rx_data !== d0) begin
      nerr++; $display("FAIL glitch_reject: busy=%b valids=%0d ferrs=%0d data=%h want 0 0 0 %h",
                       rx_busy, valid_cnt - v0, ferr_cnt - f0, rx_data, d0);
    end
  endtask

  task automatic test_break();
    int v0 = valid_cnt, f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    repeat (20 * CPB) @(negedge clk_50M);
    nvec++;
    if (ferr_cnt !== f0 + 1 || valid_cnt !== v0 || rx_busy !== 1'b1) begin
      nerr++; $display("FAIL break_hold: ferrs=%0d valids=%0d busy=%b want 1 0 1", ferr_cnt - f0, valid_cnt - v0, rx_busy);
    end
    nvec++;
    if (rx_data !== m_data || rx_full !== m_full || rx_overrun !== m_ovr) begin
      nerr++; $display("FAIL break_keep: data=%h full=%b ovr=%b want %h %b %b", rx_data, rx_full, rx_overrun, m_data, m_full, m_ovr);
    end
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk_50M);
    send_frame(8'h43, 1'b1);
    model_good(8'h43);
    nvec++;
    if (rx_data !== m_data || valid_cnt !== v0 + 1 || ferr_cnt !== f0 + 1) begin
      nerr++; $display("FAIL break_recover: data=%h valids=%0d want %h 1", rx_data, valid_cnt - v0, m_data);
    end
    pulse_read();
  endtask

  task automatic test_overrun();
    send_frame(8'h43, 1'b1); model_good(8'h43);
    send_frame(8'h65, 1'b1); model_good(8'h65);
    nvec++;
    if (rx_data !== m_data || rx_full !== m_full || rx_overrun !== m_ovr) begin
      nerr++; $display("FAIL overrun_set: data=%h full=%b ovr=%b want %h %b %b", rx_data, rx_full, rx_overrun, m_data, m_full, m_ovr);
    end
    pulse_read();
    nvec++;
    if (rx_full !== 1'b0 || rx_overrun !== 1'b0) begin
      nerr++; $display("FAIL overrun_clear: full=%b ovr=%b want 0 0", rx_full, rx_overrun);
    end
    pulse_read();
    nvec++;
    if (rx_full !== 1'b0 || rx_overrun !== 1'b0 || rx_data !== m_data) begin
      nerr++; $display("FAIL read_empty: full=%b ovr=%b data=%h want 0 0 %h", rx_full, rx_overrun, rx_data, m_data);
    end
  endtask

  task automatic test_read_collide();
    logic [7:0] b = 8'($urandom);
    send_frame(8'h3c, 1'b1); model_good(8'h3c);
    fork
      send_frame(b, 1'b1);
      begin
        @(negedge clk_50M);
        repeat (LAT - 1) @(negedge clk_50M);
        rx_read = 1'b1;
        @(negedge clk_50M) rx_read = 1'b0;
      end
    join
    m_data = b;
    nvec++;
    if (rx_data !== m_data || rx_full !== 1'b1 || rx_overrun !== 1'b0) begin
      nerr++; $display("FAIL read_collide: data=%h full=%b ovr=%b want %h 1 0", rx_data, rx_full, rx_overrun, m_data);
    end
    pulse_read();
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      logic [7:0] b = 8'($urandom);
      int v0 = valid_cnt, lat;
      send_frame(b, 1'b1);
      model_good(b);
      lat = last_valid_cyc - start_cyc;
      nvec++;
      if (rx_data !== m_data || rx_full !== m_full || rx_overrun !== m_ovr || valid_cnt !== v0 + 1 ||
          lat < LAT - 1 || lat > LAT + 1) begin
        nerr++; $display("FAIL random_%0d: data=%h full=%b ovr=%b valids=%0d lat=%0d want %h %b %b 1 %0d",
                         n, rx_data, rx_full, rx_overrun, valid_cnt - v0, lat, m_data, m_full, m_ovr, LAT);
      end
      if ($urandom_range(0, 1) == 1) pulse_read();
    end
    pulse_read();
  endtask

  task automatic test_loopback();
    logic [7:0] seq [3] = '{8'h21, 8'h43, 8'h65};
    int v0 = valid_cnt, f0 = ferr_cnt;
    for (int n = 0; n < 3; n++) begin
      send_frame(seq[n], 1'b1);
      model_good(seq[n]);
      nvec++;
      if (last_valid_data !== m_data || rx_overrun !== 1'b0 || valid_cnt !== v0 + n + 1) begin
        nerr++; $display("FAIL loopback_%0d: data=%h ovr=%b valids=%0d want %h 0 %0d",
                         n, last_valid_data, rx_overrun, valid_cnt - v0, m_data, n + 1);
      end
      pulse_read();
    end
    nvec++;
    if (ferr_cnt !== f0) begin
      nerr++; $display("FAIL loopback_ferr: ferrs=%0d want 0", ferr_cnt - f0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b = 8'h9a;
    int v0;
    send_frame(8'h12, 1'b1); model_good(8'h12);
    v0 = valid_cnt;
    @(negedge clk_50M) uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk_50M);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk_50M);
    end
    uart_rxd = b[4];
    repeat (CPB / 2) @(negedge clk_50M);
    reset_n = 1'b0;
    m_data = '0; m_full = 0; m_ovr = 0;
    @(negedge clk_50M);
    nvec++;
    if ({rx_data, rx_valid, rx_full, rx_overrun, rx_frame_err, rx_busy} !== 13'h0) begin
      nerr++; $display("FAIL reset_mid_hold: outs=%h want 0", {rx_data, rx_valid, rx_full, rx_overrun, rx_frame_err, rx_busy});
    end
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk_50M);
    reset_n = 1'b1;
    repeat (12 * CPB) @(negedge clk_50M);
    nvec++;
    if (valid_cnt !== v0 || rx_data !== 8'h00 || rx_busy !== 1'b0) begin
      nerr++; $display("FAIL reset_mid_abort: valids=%0d data=%h busy=%b want 0 00 0", valid_cnt - v0, rx_data, rx_busy);
    end
    send_frame(8'h65, 1'b1); model_good(8'h65);
    nvec++;
    if (rx_data !== m_data || rx_full !== 1'b1 || valid_cnt !== v0 + 1) begin
      nerr++; $display("FAIL reset_mid_after: data=%h full=%b valids=%0d want %h 1 1", rx_data, rx_full, valid_cnt - v0, m_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_break();
    test_overrun();
    test_read_collide();
    test_random();
    test_loopback();
    test_reset_mid();
    repeat (4) @(negedge clk_50M);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: cycle=%0d, run did not complete", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
